axi_read_fsm: RTL and testbench

//   Single-beat AXI4 read master: on a start pulse, fetches one 32-bit word from a 12-bit address.

---
 rtl/axi_rd_pkg.sv | 22 ++
 rtl/axi_read_fsm.sv | 119 +++++++++++
 tb/tb_axi_read_fsm.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_rd_pkg.sv
// Shared types and AXI read-channel attribute constants for the single-beat read master.
package axi_rd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } rd_state_e;

  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [3:0] AXI_CACHE_DEF  = 4'b0011;
  localparam logic [7:0] AXI_LEN_1BEAT  = 8'd0;
  localparam logic       AXI_LOCK_NORM  = 1'b0;
  localparam logic [2:0] AXI_PROT_DEF   = 3'b000;

  function automatic logic [11:0] word_align(input logic [11:0] addr);
    return {addr[11:2], 2'b00};
  endfunction

endpackage

// File: rtl/axi_read_fsm.sv
// Single-beat AXI4 read master: a start pulse fetches one 32-bit word and
// reports it with a one-cycle valid pulse; read_data holds until the next read.
module axi_read_fsm
  import axi_rd_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [11:0] read_addr,
  output logic [31:0] read_data,
  output logic        valid,
  output logic        busy,
  output logic [11:0] m_axi_araddr,
  output logic [2:0]  m_axi_arsize,
  output logic        m_axi_arvalid,
  output logic [1:0]  m_axi_arburst,
  output logic [3:0]  m_axi_arcache,
  output logic [7:0]  m_axi_arlen,
  output logic        m_axi_arlock,
  output logic [2:0]  m_axi_arprot,
  input  logic        m_axi_arready,
  input  logic [31:0] m_axi_rdata,
  input  logic        m_axi_rvalid,
  input  logic        m_axi_rlast,
  output logic        m_axi_rready
);

  rd_state_e   state_q, state_d;
  logic [11:0] araddr_q, araddr_d;
  logic        arvalid_q, arvalid_d;
  logic        rready_q, rready_d;
  logic        valid_q, valid_d;
  logic [31:0] read_data_q, read_data_d;

  // Next-state and next-output computation; handshakes only count in their own state.
  always_comb begin
    state_d     = state_q;
    araddr_d    = araddr_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    valid_d     = 1'b0;
    read_data_d = read_data_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          araddr_d  = word_align(read_addr);
          arvalid_d = 1'b1;
          state_d   = ADDR;
        end else begin
          arvalid_d = 1'b0;
        end
      end
      ADDR: begin
        if (arvalid_q && m_axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = DATA;
        end else begin
          arvalid_d = 1'b1;
        end
      end
      DATA: begin
        // First beat completes the read; rlast plays no part since arlen is zero.
        if (rready_q && m_axi_rvalid) begin
          read_data_d = m_axi_rdata;
          rready_d    = 1'b0;
          valid_d     = 1'b1;
          state_d     = DONE;
        end else begin
          rready_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        arvalid_d = 1'b0;
        rready_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      araddr_q    <= 12'h000;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      valid_q     <= 1'b0;
      read_data_q <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      araddr_q    <= araddr_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      valid_q     <= valid_d;
      read_data_q <= read_data_d;
    end
  end

  assign read_data     = read_data_q;
  assign valid         = valid_q;
  assign busy          = (state_q != IDLE);
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;
  assign m_axi_arsize  = AXI_SIZE_4B;
  assign m_axi_arburst = AXI_BURST_INCR;
  assign m_axi_arcache = AXI_CACHE_DEF;
  assign m_axi_arlen   = AXI_LEN_1BEAT;
  assign m_axi_arlock  = AXI_LOCK_NORM;
  assign m_axi_arprot  = AXI_PROT_DEF;

  logic unused_ok;
  assign unused_ok = ^{m_axi_rlast, read_addr[1:0]};

endmodule

// File: tb/tb_axi_read_fsm.sv
// Randomized bench for axi_read_fsm: a scoreboard of expected AR addresses and
// returned words, a delay-programmable slave, and an independent monitor.
module tb_axi_read_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [11:0] read_addr;
  logic [31:0] read_data;
  logic        valid;
  logic        busy;
  logic [11:0] m_axi_araddr;
  logic [2:0]  m_axi_arsize;
  logic        m_axi_arvalid;
  logic [1:0]  m_axi_arburst;
  logic [3:0]  m_axi_arcache;
  logic [7:0]  m_axi_arlen;
  logic        m_axi_arlock;
  logic [2:0]  m_axi_arprot;
  logic        m_axi_arready;
  logic [31:0] m_axi_rdata;
  logic        m_axi_rvalid;
  logic        m_axi_rlast;
  logic        m_axi_rready;

  always #5 clk = ~clk;

  axi_read_fsm dut (
    .clk(clk), .rst(rst), .start(start), .read_addr(read_addr),
    .read_data(read_data), .valid(valid), .busy(busy),
    .m_axi_araddr(m_axi_araddr), .m_axi_arsize(m_axi_arsize),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arburst(m_axi_arburst),
    .m_axi_arcache(m_axi_arcache), .m_axi_arlen(m_axi_arlen),
    .m_axi_arlock(m_axi_arlock), .m_axi_arprot(m_axi_arprot),
    .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rlast(m_axi_rlast),
    .m_axi_rready(m_axi_rready)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] mem [0:1023];
  logic [11:0] exp_addr_q [$];
  logic [31:0] exp_data_q [$];
  int          ar_delay   = 0;
  int          r_delay    = 0;
  bit          noise_en   = 1'b0;
  bit          busy_noise = 1'b0;
  bit          in_reset   = 1'b1;
  int          valid_count = 0;
  logic [31:0] last_data  = 32'h0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Slave: counts cycles a request has been waiting and answers after the programmed delay.
  initial begin
    int          ar_cnt = 0;
    int          r_cnt  = 0;
    logic [11:0] r_addr = 12'h0;
    m_axi_arready = 1'b0;
    m_axi_rvalid  = 1'b0;
    m_axi_rdata   = 32'h0;
    m_axi_rlast   = 1'b0;
    forever begin
      @(negedge clk);
      if (m_axi_arvalid === 1'b1) begin
        m_axi_arready = (ar_cnt >= ar_delay);
        ar_cnt++;
        if (m_axi_arready) r_addr = m_axi_araddr;
      end else begin
        ar_cnt = 0;
        m_axi_arready = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      if (m_axi_rready === 1'b1) begin
        m_axi_rvalid = (r_cnt >= r_delay);
        r_cnt++;
        m_axi_rdata  = m_axi_rvalid ? mem[r_addr[11:2]] : $urandom;
        m_axi_rlast  = m_axi_rvalid;
      end else begin
        r_cnt = 0;
        m_axi_rvalid = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
        m_axi_rdata  = $urandom;
        m_axi_rlast  = 1'($urandom_range(0, 1));
      end
    end
  end

  // Monitor: compares every AR handshake and valid pulse against the scoreboard.
  initial begin
    logic        prev_wait = 1'b0;
    logic [11:0] prev_addr = 12'h0;
    forever begin
      @(negedge clk);
      #1;
      if (in_reset) begin
        prev_wait = 1'b0;
      end else begin
        check("busy", busy, m_axi_arvalid | m_axi_rready | valid);
        if (prev_wait) begin
          check("ar_hold_valid", m_axi_arvalid, 1'b1);
          check("ar_hold_addr", m_axi_araddr, prev_addr);
        end
        if (m_axi_arvalid && m_axi_arready) begin
          check("ar_expected", exp_addr_q.size() != 0, 1'b1);
          if (exp_addr_q.size() != 0) check("araddr", m_axi_araddr, exp_addr_q.pop_front());
          check("ar_attrs", {m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arcache, m_axi_arlock, m_axi_arprot},
                {8'd0, 3'b010, 2'b01, 4'b0011, 1'b0, 3'b000});
        end
        if (valid) begin
          valid_count++;
          check("valid_expected", exp_data_q.size() != 0, 1'b1);
          if (exp_data_q.size() != 0) begin
            last_data = exp_data_q.pop_front();
            check("read_data", read_data, last_data);
          end
        end else begin
          check("read_data_hold", read_data, last_data);
        end
        prev_wait = m_axi_arvalid && !m_axi_arready;
        prev_addr = m_axi_araddr;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    in_reset = 1'b1;
    rst = 1'b1;
    start = 1'b0;
    @(negedge clk);
    #2;
    check("rst_arvalid", m_axi_arvalid, 1'b0);
    check("rst_rready", m_axi_rready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_valid", valid, 1'b0);
    check("rst_read_data", read_data, 32'h0);
    check("rst_araddr", m_axi_araddr, 12'h0);
    exp_addr_q.delete();
    exp_data_q.delete();
    last_data = 32'h0;
    rst = 1'b0;
    in_reset = 1'b0;
  endtask

  // One read: expected latency with immediate slave answers is three cycles plus delays.
  task automatic do_read(input logic [11:0] addr, input int ard, input int rd);
    int lat;
    bit done;
    ar_delay = ard;
    r_delay  = rd;
    @(negedge clk);
    start = 1'b1;
    read_addr = addr;
    exp_addr_q.push_back({addr[11:2], 2'b00});
    exp_data_q.push_back(mem[addr[11:2]]);
    lat = 0;
    done = 1'b0;
    while (!done && lat < 200) begin
      @(negedge clk);
      #2;
      lat++;
      start = 1'b0;
      if (valid) done = 1'b1;
      else if (busy_noise && $urandom_range(0, 2) == 0) begin
        start = 1'b1;
        read_addr = 12'($urandom);
      end
    end
    start = 1'b0;
    check("latency", lat, 3 + ard + rd);
  endtask

  initial begin
    int          vc0;
    int          w;
    logic [11:0] a;
    rst = 1'b1;
    start = 1'b0;
    read_addr = 12'h0;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    do_reset();

    mem[2] = 32'hDDCCBBAA;
    do_read(12'h008, 0, 0);
    @(negedge clk);
    #2;
    check("t1_hold_next", read_data, 32'hDDCCBBAA);

    do_read(12'h104, 5, 0);
    mem[4] = 32'h12345678;
    do_read(12'h010, 0, 3);

    busy_noise = 1'b1;
    do_read(12'h00E, 2, 2);
    busy_noise = 1'b0;

    ar_delay = 0;
    r_delay  = 50;
    @(negedge clk);
    start = 1'b1;
    read_addr = 12'h0A4;
    exp_addr_q.push_back(12'h0A4);
    exp_data_q.push_back(mem[12'h0A4 >> 2]);
    w = 0;
    do begin
      @(negedge clk);
      #2;
      start = 1'b0;
      w++;
    end while (!m_axi_rready && w < 50);
    check("reach_data", m_axi_rready, 1'b1);
    check("addr_q_drained", exp_addr_q.size(), 0);
    do_reset();
    r_delay = 0;

    vc0 = valid_count;
    for (int i = 0; i < 8; i++) do_read(12'(i * 8), 0, 0);
    check("burst8_valids", valid_count - vc0, 8);

    noise_en = 1'b1;
    busy_noise = 1'b1;
    for (int i = 0; i < 40; i++) begin
      a = 12'($urandom);
      do_read(a, $urandom_range(0, 4), $urandom_range(0, 4));
    end

    repeat (3) @(negedge clk);
    #2;
    check("end_addr_q_empty", exp_addr_q.size(), 0);
    check("end_data_q_empty", exp_data_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
